// File: rtl/demux_pkg.sv
// Shared types and constants for the demux_stream_n slice.
// The counter constants are only consumed when DEMUX_CNT_EN is defined.
package demux_pkg;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {EMPTY, FULL} slot_state_e;

    // All-ones idle beat; callers take the low DW bits (DW <= 64).
    function automatic logic [63:0] IDLE_BEAT();
        return '1;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One output lane: EMPTY/FULL holding register, idle-high data, optional
// handshake counter (DEMUX_CNT_EN).
module demux_slot
    import demux_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iLoad,
    input  logic [DW-1:0] iData,
    input  logic          iReady,
    output logic          oValid,
    output logic [DW-1:0] oData,
    output logic          oFree
`ifdef DEMUX_CNT_EN
    ,
    input  logic             iClr,
    output logic [CNT_W-1:0] oCnt
`endif
);

    localparam logic [63:0] IDLE_WIDE = IDLE_BEAT();

    slot_state_e state;

    // iLoad only arrives while oFree, so a FULL slot seeing iLoad is draining too.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= EMPTY;
            oData <= IDLE_WIDE[DW-1:0];
        end else begin
            case (state)
                EMPTY: begin
                    if (iLoad) begin
                        state <= FULL;
                        oData <= iData;
                    end
                end
                FULL: begin
                    if (iLoad) begin
                        oData <= iData;
                    end else if (iReady) begin
                        state <= EMPTY;
                        oData <= IDLE_WIDE[DW-1:0];
                    end
                end
                default: begin
                    state <= EMPTY;
                    oData <= IDLE_WIDE[DW-1:0];
                end
            endcase
        end
    end

    assign oValid = (state == FULL);
    assign oFree  = (state == EMPTY) | iReady;

`ifdef DEMUX_CNT_EN
    always_ff @(posedge iClk) begin
        if (iRst || iClr) begin
            oCnt <= '0;
        end else if (oValid && iReady && (oCnt != CNT_MAX)) begin
            oCnt <= oCnt + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/demux_stream_n.sv
// Registered 1-to-CH stream demultiplexer with per-lane slot registers.
// Optional per-lane handshake counters: define DEMUX_CNT_EN.
module demux_stream_n
    import demux_pkg::*;
#(
    parameter int CH = 4,
    parameter int DW = 8,
    parameter int SW = $clog2(CH)
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iValid,
    input  logic [SW-1:0]    iSel,
    input  logic [DW-1:0]    iData,
    output logic             oReady,
    output logic [CH-1:0]    oValid,
    output logic [CH*DW-1:0] oData,
    input  logic [CH-1:0]    iReady,
    output logic             oErr
`ifdef DEMUX_CNT_EN
    ,
    input  logic                iClr,
    output logic [CH*CNT_W-1:0] oCnt
`endif
);

    logic [CH-1:0] free;
    logic [CH-1:0] load;
    logic          inRange;
    logic          selFree;
    logic          accept;

    // Out-of-range selects are always accepted (and dropped) so they never stall.
    always_comb begin
        inRange = 1'b0;
        selFree = 1'b0;
        for (int unsigned k = 0; k < CH; k++) begin
            if (iSel == SW'(k)) begin
                inRange = 1'b1;
                selFree = free[k];
            end
        end
        oReady = !iRst && (!inRange || selFree);
    end

    assign accept = iValid && oReady;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            oErr <= 1'b0;
        end else begin
            oErr <= accept && !inRange;
        end
    end

    for (genvar k = 0; k < CH; k++) begin : gLane
        assign load[k] = accept && (iSel == SW'(k));

        demux_slot #(
            .DW(DW)
        ) uSlot (
            .iClk  (iClk),
            .iRst  (iRst),
            .iLoad (load[k]),
            .iData (iData),
            .iReady(iReady[k]),
            .oValid(oValid[k]),
            .oData (oData[k*DW +: DW]),
            .oFree (free[k])
`ifdef DEMUX_CNT_EN
            ,
            .iClr  (iClr),
            .oCnt  (oCnt[k*CNT_W +: CNT_W])
`endif
        );
    end

endmodule
